// File: rtl/updown_counter_axil_slave.sv
// AXI4-Lite register slave wrapping a prescaled up/down counter with a sticky
// terminal-count flag that also drives a level interrupt.
`timescale 1ns/1ps
module updown_counter_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     count_o,
    output logic                            tc_irq
);

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESCALE = 2'd1;
    localparam logic [1:0] REG_MAX      = 2'd2;
    localparam logic [1:0] REG_COUNT    = 2'd3;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

    logic        aw_ready_r, bvalid_r, ar_ready_r, rvalid_r;
    logic [31:0] rdata_r;
    logic        ctrl_en_r, ctrl_dir_r, tc_r;
    logic [31:0] prescale_r, max_r, count_r, presc_cnt_r;

    logic        wr_fire_s, rd_fire_s, tick_s, tc_set_s, tc_clr_s;
    logic [1:0]  wr_sel_s;
    logic [31:0] presc_nxt_s, count_nxt_s, rd_mux_s;
    logic        unused_s;

    // AWREADY/WREADY is a one-cycle pulse, so the handshake completes on the cycle it is high
    assign wr_fire_s = aw_ready_r && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire_s = ar_ready_r && S_AXI_ARVALID;
    assign wr_sel_s  = S_AXI_AWADDR[3:2];
    assign tc_clr_s  = wr_fire_s && (wr_sel_s == REG_CTRL) && S_AXI_WSTRB[1] && S_AXI_WDATA[8];
    assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = aw_ready_r;
    assign S_AXI_WREADY  = aw_ready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = rdata_r;
    assign count_o       = count_r;
    assign tc_irq        = tc_r;

    // Prescaler: free-runs while enabled and emits a single-cycle tick on match
    always_comb begin
        tick_s      = 1'b0;
        presc_nxt_s = presc_cnt_r;
        if (!ctrl_en_r) begin
            presc_nxt_s = 32'd0;
        end else if (presc_cnt_r == prescale_r) begin
            presc_nxt_s = 32'd0;
            tick_s      = 1'b1;
        end else begin
            presc_nxt_s = presc_cnt_r + 32'd1;
        end
    end

    // Counter step on tick, using the direction held before any same-cycle CTRL write
    always_comb begin
        count_nxt_s = count_r;
        tc_set_s    = 1'b0;
        if (tick_s) begin
            if (!ctrl_dir_r) begin
                if (count_r >= max_r) begin
                    count_nxt_s = 32'd0;
                    tc_set_s    = 1'b1;
                end else begin
                    count_nxt_s = count_r + 32'd1;
                end
            end else begin
                if (count_r == 32'd0) begin
                    count_nxt_s = max_r;
                    tc_set_s    = 1'b1;
                end else begin
                    count_nxt_s = count_r - 32'd1;
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Read data mux
    always_comb begin
        rd_mux_s = 32'd0;
        case (S_AXI_ARADDR[3:2])
            REG_CTRL:     rd_mux_s = {23'd0, tc_r, 6'd0, ctrl_dir_r, ctrl_en_r};
            REG_PRESCALE: rd_mux_s = prescale_r;
            REG_MAX:      rd_mux_s = max_r;
            REG_COUNT:    rd_mux_s = count_r;
            default:      rd_mux_s = 32'd0;
        endcase
    end

    // Write channel handshake: accept AW and W together only when no response is pending
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_ready_r <= 1'b0;
            bvalid_r   <= 1'b0;
        end else begin
            if (aw_ready_r) begin
                aw_ready_r <= 1'b0;
            end else if (S_AXI_AWVALID && S_AXI_WVALID && !bvalid_r) begin
                aw_ready_r <= 1'b1;
            end else begin
                aw_ready_r <= 1'b0;
            end
            if (wr_fire_s) begin
                bvalid_r <= 1'b1;
            end else if (bvalid_r && S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read channel handshake and data capture
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ar_ready_r <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            if (ar_ready_r) begin
                ar_ready_r <= 1'b0;
            end else if (S_AXI_ARVALID && !rvalid_r) begin
                ar_ready_r <= 1'b1;
            end else begin
                ar_ready_r <= 1'b0;
            end
            if (rd_fire_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_mux_s;
            end else if (rvalid_r && S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Control registers, counter and sticky TC flag (set beats clear)
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_en_r   <= 1'b0;
            ctrl_dir_r  <= 1'b0;
            tc_r        <= 1'b0;
            prescale_r  <= 32'd0;
            max_r       <= 32'd0;
            count_r     <= 32'd0;
            presc_cnt_r <= 32'd0;
        end else begin
            presc_cnt_r <= presc_nxt_s;
            count_r     <= count_nxt_s;
            if (tc_set_s) begin
                tc_r <= 1'b1;
            end else if (tc_clr_s) begin
                tc_r <= 1'b0;
            end
            if (wr_fire_s) begin
                case (wr_sel_s)
                    REG_CTRL: begin
                        if (S_AXI_WSTRB[0]) begin
                            ctrl_en_r  <= S_AXI_WDATA[0];
                            ctrl_dir_r <= S_AXI_WDATA[1];
                        end
                    end
                    REG_PRESCALE: prescale_r <= apply_wstrb(prescale_r, S_AXI_WDATA, S_AXI_WSTRB);
                    REG_MAX:      max_r      <= apply_wstrb(max_r, S_AXI_WDATA, S_AXI_WSTRB);
                    REG_COUNT:    begin end
                    default:      begin end
                endcase
            end
        end
    end

endmodule
